// File: rtl/step_sequencer_if.sv
// Run/step handshake between the board keys, the control unit and the step sequencer.
// The master side drives the keys and control-unit status; the slave side is the sequencer.
interface step_sequencer_if #(
    parameter int RW = 8
);
    logic          run;
    logic          step_mode;
    logic          step;
    logic          instr_end;
    logic          halt;
    logic [1:0]    counter;
    logic          fetch;
    logic          running;
    logic          paused;
    logic          halted;
    logic [RW-1:0] retired;

    modport master (
        output run, step_mode, step, instr_end, halt,
        input  counter, fetch, running, paused, halted, retired
    );

    modport slave (
        input  run, step_mode, step, instr_end, halt,
        output counter, fetch, running, paused, halted, retired
    );
endinterface

// File: rtl/step_sequencer.sv
// Step counter and run/pause/halt control for one processor's control unit.
// Every output comes from registered state, so no input reaches an output combinationally.
module step_sequencer #(
    parameter int STEP_MAX = 3,
    parameter int RW       = 8
) (
    input  logic            clock,
    input  logic            reset_n,
    step_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        PAUSE = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [1:0] STEP_LAST = 2'(STEP_MAX);

    state_t        state_r;
    logic [1:0]    counter_r;
    logic [RW-1:0] retired_r;
    logic          step_q_r;
    logic          boundary_s;
    logic          step_rise_s;

    // A forced boundary at STEP_LAST keeps the counter from ever passing it.
    assign boundary_s  = bus.instr_end || (counter_r == STEP_LAST);
    assign step_rise_s = bus.step && !step_q_r;

    // Sequencer state machine: state, step counter, retired count and step-key history.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            counter_r <= 2'd0;
            retired_r <= '0;
            step_q_r  <= 1'b0;
        end else begin
            // Sampled in every state so a key already held on entry to PAUSE is not an edge.
            step_q_r <= bus.step;
            case (state_r)
                IDLE: begin
                    counter_r <= 2'd0;
                    if (bus.run) begin
                        state_r   <= EXEC;
                        retired_r <= '0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    if (bus.halt) begin
                        state_r   <= HALT;
                        counter_r <= 2'd0;
                    end else if (boundary_s) begin
                        retired_r <= retired_r + RW'(1'b1);
                        counter_r <= 2'd0;
                        if (!bus.run) begin
                            state_r <= IDLE;
                        end else if (bus.step_mode) begin
                            state_r <= PAUSE;
                        end else begin
                            state_r <= EXEC;
                        end
                    end else begin
                        counter_r <= counter_r + 2'd1;
                    end
                end
                PAUSE: begin
                    counter_r <= 2'd0;
                    if (!bus.run) begin
                        state_r <= IDLE;
                    end else if (step_rise_s) begin
                        state_r <= EXEC;
                    end else begin
                        state_r <= PAUSE;
                    end
                end
                HALT: begin
                    // Leaving HALT needs run low first; holding run high never restarts.
                    counter_r <= 2'd0;
                    if (!bus.run) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= HALT;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    counter_r <= 2'd0;
                end
            endcase
        end
    end

    assign bus.counter = counter_r;
    assign bus.retired = retired_r;
    assign bus.running = (state_r == EXEC);
    assign bus.paused  = (state_r == PAUSE);
    assign bus.halted  = (state_r == HALT);
    assign bus.fetch   = (state_r == EXEC) && (counter_r == 2'd0);
endmodule

// File: tb/tb_step_sequencer.sv
// Randomized bench for step_sequencer against a behavioural model, plus directed scenarios.
module tb_step_sequencer;
    localparam int STEP_MAX = 3;
    localparam int RW       = 8;
    localparam int MI = 0, ME = 1, MP = 2, MH = 3;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    int m_mode = MI;
    int m_step = 0;
    int m_ret  = 0;
    bit m_prev = 1'b0;

    step_sequencer_if #(.RW(RW)) bus ();

    step_sequencer #(.STEP_MAX(STEP_MAX), .RW(RW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: instruction progress as a plain integer, retired count unbounded.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_mode <= MI;
            m_step <= 0;
            m_ret  <= 0;
            m_prev <= 1'b0;
        end else begin
            m_prev <= bus.step;
            if (m_mode == MI) begin
                if (bus.run) begin
                    m_mode <= ME;
                    m_ret  <= 0;
                end
            end else if (m_mode == ME) begin
                if (bus.halt) begin
                    m_mode <= MH;
                    m_step <= 0;
                end else if (bus.instr_end || m_step == STEP_MAX) begin
                    m_ret  <= m_ret + 1;
                    m_step <= 0;
                    m_mode <= !bus.run ? MI : (bus.step_mode ? MP : ME);
                end else begin
                    m_step <= m_step + 1;
                end
            end else if (m_mode == MP) begin
                if (!bus.run) m_mode <= MI;
                else if (bus.step && !m_prev) m_mode <= ME;
            end else begin
                if (!bus.run) m_mode <= MI;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        logic [13:0] act;
        logic [13:0] exp;
        act = {bus.counter, bus.fetch, bus.running, bus.paused, bus.halted, bus.retired};
        exp = {2'(m_step), (m_mode == ME) && (m_step == 0), m_mode == ME, m_mode == MP,
               m_mode == MH, 8'(m_ret % 256)};
        check("model_cycle", 32'(act), 32'(exp));
    end

    task automatic cyc(input bit r, input bit sm, input bit st, input bit ie, input bit h);
        @(negedge clock);
        bus.run = r; bus.step_mode = sm; bus.step = st; bus.instr_end = ie; bus.halt = h;
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        bus.run = 1'b0; bus.step_mode = 1'b0; bus.step = 1'b0; bus.instr_end = 1'b0; bus.halt = 1'b0;
        #2 reset_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        bus.run = 1'b0; bus.step_mode = 1'b0; bus.step = 1'b0; bus.instr_end = 1'b0; bus.halt = 1'b0;
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b1;
        #1;
        check("reset_outputs",
              32'({bus.counter, bus.fetch, bus.running, bus.paused, bus.halted, bus.retired}), 32'd0);

        // T1 plain run
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t1_start_running", 32'(bus.running), 32'd1);
        check("t1_start_fetch", 32'(bus.fetch), 32'd1);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, 1'b0, (i % 2) == 1, 1'b0);
            check("t1_counter", 32'(bus.counter), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        check("t1_retired", 32'(bus.retired), 32'd5);
        check("t1_model_retired", 32'(m_ret), 32'd5);

        // T2 forced wrap at STEP_MAX
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            check("t2_counter", 32'(bus.counter), 32'((i + 1) % 4));
            check("t2_retired", 32'(bus.retired), 32'(5 + (i + 1) / 4));
        end

        // T3 single step
        apply_reset();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t3_exec", 32'(bus.running), 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("t3_paused", 32'(bus.paused), 32'd1);
        check("t3_counter", 32'(bus.counter), 32'd0);
        check("t3_retired1", 32'(bus.retired), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            check("t3_hold_paused", 32'(bus.paused), 32'd1);
        end
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("t3_released", 32'(bus.running), 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("t3_repaused", 32'(bus.paused), 32'd1);
        check("t3_retired2", 32'(bus.retired), 32'd2);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("t3_held_once", 32'(bus.retired), 32'd3);
        check("t3_held_paused", 32'(bus.paused), 32'd1);

        // T4 halt beats instr_end
        apply_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_counter2", 32'(bus.counter), 32'd2);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check("t4_halted", 32'(bus.halted), 32'd1);
        check("t4_counter0", 32'(bus.counter), 32'd0);
        check("t4_retired_kept", 32'(bus.retired), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            check("t4_stays_halted", 32'(bus.halted), 32'd1);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_idle", 32'({bus.running, bus.halted}), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_restart_running", 32'(bus.running), 32'd1);
        check("t4_restart_retired", 32'(bus.retired), 32'd0);

        // T5 run drops mid-instruction
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t5_counter1", 32'(bus.counter), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t5_counter2", 32'({bus.running, bus.counter}), 32'h6);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t5_counter3", 32'({bus.running, bus.counter}), 32'h7);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t5_idle", 32'({bus.running, bus.counter}), 32'h0);
        check("t5_retired", 32'(bus.retired), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            check("t5_still", 32'({bus.running, bus.counter}), 32'h0);
        end

        // T6 asynchronous reset mid-instruction
        apply_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_counter2", 32'(bus.counter), 32'd2);
        check("t6_model_step", 32'(m_step), 32'd2);
        #1 reset_n = 1'b0;
        #1;
        check("t6_async_clear",
              32'({bus.counter, bus.fetch, bus.running, bus.paused, bus.halted, bus.retired}), 32'd0);
        @(negedge clock);
        #2 reset_n = 1'b1;

        // Randomized traffic, with occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            bus.run       = ($urandom_range(0, 9) != 0);
            bus.step_mode = ($urandom_range(0, 2) == 0);
            bus.step      = ($urandom_range(0, 4) == 0);
            bus.instr_end = ($urandom_range(0, 2) == 0);
            bus.halt      = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 reset_n = 1'b0;
                @(negedge clock);
                #2 reset_n = 1'b1;
            end
        end

        @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
